// File: rtl/adc_scan_sequencer.sv
// Channel-scan sequencer: walks an enabled-channel mask, requests ADC conversions,
// drops post-switch samples, averages a power-of-two block and flags silent channels.
module adc_scan_sequencer #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int DISCARD  = 1,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic [N_CH-1:0]          ch_mask,
  output logic                     conv_req,
  output logic [$clog2(N_CH)-1:0]  conv_ch,
  input  logic                     conv_ack,
  input  logic [DATA_W-1:0]        conv_data,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic [N_CH-1:0]          data_valid,
  output logic                     scan_done,
  output logic                     busy,
  output logic [N_CH-1:0]          ch_err
);

  localparam int CW = $clog2(N_CH);
  localparam int PW = CW + 1;
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]    DISC_N   = 4'(DISCARD);
  localparam logic [SW-1:0] SMP_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [N_CH-1:0] mask_q;
  logic [PW-1:0]   ptr;
  logic [3:0]      disc_cnt;
  logic [SW-1:0]   smp_cnt;
  logic [AW-1:0]   acc;
  logic [TW-1:0]   timer;

  logic            found;
  logic [CW-1:0]   found_idx;
  logic            take;
  logic            discarding;
  logic            last_smp;
  logic            expired;
  logic [AW-1:0]   sum;
  logic [DATA_W-1:0] avg;

  // Lowest enabled channel at or above ptr; ptr == N_CH never matches.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (PW'(i) >= ptr)) begin
        found     = 1'b1;
        found_idx = CW'(i);
      end
    end
  end

  assign take       = (state == REQ) && conv_ack;
  assign discarding = (disc_cnt != DISC_N);
  assign last_smp   = take && !discarding && (smp_cnt == SMP_LAST);
  assign expired    = (state == REQ) && !conv_ack && (timer == TMR_LAST);
  assign sum        = acc + AW'(conv_data);
  assign avg        = DATA_W'(sum >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if ((en || start) && (ch_mask != '0)) state_nx = SELECT;
      SELECT:  state_nx = found ? REQ : DONE;
      REQ:     if (last_smp || expired) state_nx = SELECT;
      DONE:    state_nx = (en && (ch_mask != '0)) ? SELECT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    conv_req  = (state == REQ);
    busy      = (state != IDLE);
    scan_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      ptr        <= '0;
      disc_cnt   <= '0;
      smp_cnt    <= '0;
      acc        <= '0;
      timer      <= '0;
      conv_ch    <= '0;
      data_out   <= '0;
      data_valid <= '0;
      ch_err     <= '0;
    end else begin
      data_valid <= '0;
      unique case (state)
        IDLE: begin
          if (state_nx == SELECT) begin
            mask_q <= ch_mask;
            ptr    <= '0;
          end
        end
        SELECT: begin
          if (found) begin
            conv_ch  <= found_idx;
            ptr      <= PW'(found_idx);
            disc_cnt <= '0;
            smp_cnt  <= '0;
            acc      <= '0;
            timer    <= '0;
          end
        end
        REQ: begin
          if (take) begin
            timer <= '0;
            if (discarding) begin
              disc_cnt <= disc_cnt + 4'd1;
            end else begin
              acc     <= sum;
              smp_cnt <= smp_cnt + SW'(1);
            end
            if (last_smp) begin
              for (int i = 0; i < N_CH; i++) begin
                if (ptr == PW'(i)) begin
                  data_out[i*DATA_W +: DATA_W] <= avg;
                  data_valid[i]                <= 1'b1;
                  ch_err[i]                    <= 1'b0;
                end
              end
              ptr <= ptr + PW'(1);
            end
          end else if (expired) begin
            // Silent channel: keep its last result, flag it and move on.
            for (int i = 0; i < N_CH; i++) begin
              if (ptr == PW'(i)) ch_err[i] <= 1'b1;
            end
            ptr <= ptr + PW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          if (en) begin
            mask_q <= ch_mask;
            ptr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: an ack responder feeds per-channel sample
// ramps, a scoreboard matches every data_valid strobe against an expected queue.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;
  localparam int N_CH   = 4;
  localparam int DATA_W = 12;
  localparam int CW     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    en = 1'b0, start = 1'b0;
  logic [N_CH-1:0]         ch_mask = '0;
  logic                    conv_req;
  logic [CW-1:0]           conv_ch;
  logic                    conv_ack = 1'b0;
  logic [DATA_W-1:0]       conv_data = '0;
  logic [N_CH*DATA_W-1:0]  data_out;
  logic [N_CH-1:0]         data_valid;
  logic                    scan_done, busy;
  logic [N_CH-1:0]         ch_err;

  logic                    en_l = 1'b0, start_l = 1'b0;
  logic [N_CH-1:0]         ch_mask_l = 4'hF;
  logic                    conv_req_l;
  logic [CW-1:0]           conv_ch_l;
  logic                    conv_ack_l = 1'b0;
  logic [DATA_W-1:0]       conv_data_l = 12'hFFF;
  logic [N_CH*DATA_W-1:0]  data_out_l;
  logic [N_CH-1:0]         data_valid_l;
  logic                    scan_done_l, busy_l;
  logic [N_CH-1:0]         ch_err_l;

  adc_scan_sequencer #(.N_CH(4), .DATA_W(12), .AVG_LOG2(2), .DISCARD(1), .TIMEOUT(50)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .ch_mask(ch_mask),
    .conv_req(conv_req), .conv_ch(conv_ch), .conv_ack(conv_ack), .conv_data(conv_data),
    .data_out(data_out), .data_valid(data_valid), .scan_done(scan_done), .busy(busy),
    .ch_err(ch_err)
  );

  adc_scan_sequencer #(.N_CH(4), .DATA_W(12), .AVG_LOG2(0), .DISCARD(0), .TIMEOUT(50)) u_lim (
    .clk(clk), .rst(rst), .en(en_l), .start(start_l), .ch_mask(ch_mask_l),
    .conv_req(conv_req_l), .conv_ch(conv_ch_l), .conv_ack(conv_ack_l), .conv_data(conv_data_l),
    .data_out(data_out_l), .data_valid(data_valid_l), .scan_done(scan_done_l), .busy(busy_l),
    .ch_err(ch_err_l)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0]   exp_q[$];
  logic [CW-1:0] req_log[$];
  int scan_cnt       = 0;
  int ch2_req_cycles = 0;
  bit busy_seen      = 1'b0;
  int idx            = 0;
  bit gap            = 1'b0;
  int silent_ch      = -1;
  int base           = 100;
  int step           = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice(input logic [N_CH*DATA_W-1:0] d, input int ch);
    return d[ch*DATA_W +: DATA_W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scans(input int target);
    int c = 0;
    while (scan_cnt < target && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    check("scan_wait", scan_cnt >= target, 1);
  endtask

  // Ramp base+step*ch+{0,1,2,3} after one junk sample averages to base+step*ch+1.
  task automatic push_scan(input logic [N_CH-1:0] m);
    for (int c = 0; c < N_CH; c++)
      if (m[c] && c != silent_ch) exp_q.push_back({4'(c), 12'(base + step * c + 1)});
  endtask

  // ---------------- ack responders ----------------
  initial begin
    forever begin
      @(negedge clk);
      conv_ack = 1'b0;
      if (!conv_req || rst) begin
        idx = 0; gap = 1'b0;
      end else if (gap) begin
        gap = 1'b0;
      end else if (int'(conv_ch) != silent_ch) begin
        conv_data = (idx == 0) ? 12'hFFF : 12'(base + step * int'(conv_ch) + idx - 1);
        conv_ack  = 1'b1;
        idx++;
        gap = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      conv_ack_l = conv_req_l;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (conv_req && !req_prev) req_log.push_back(conv_ch);
      req_prev = conv_req;
      if (conv_req && conv_ch == 2'd2) ch2_req_cycles++;
      if (busy) busy_seen = 1'b1;
      if (scan_done) begin
        scan_cnt++;
        check("done_vs_valid", data_valid, 0);
      end
      for (int i = 0; i < N_CH; i++) begin
        if (data_valid[i]) begin
          if (exp_q.size() == 0) check("valid_extra", exp_q.size(), 1);
          else check($sformatf("valid_ch%0d", i), {4'(i), slice(data_out, i)}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int s0;
    int c;
    int dv_l;

    do_reset();
    @(posedge clk); #1;
    check("rst_conv_req", conv_req, 0);
    check("rst_conv_ch", conv_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", ch_err, 0);
    check("rst_data", data_out, 0);

    // Single scan, all channels average to 101.
    base = 100; step = 0; ch_mask = 4'hF;
    req_log.delete(); push_scan(4'hF);
    pulse_start(); wait_scans(1); idle(5);
    check("t1_busy", busy, 0);
    check("t1_scans", scan_cnt, 1);
    check("t1_req_n", req_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_conv_ch%0d", i), req_log[i], i);
    check("t1_data", data_out, {12'd101, 12'd101, 12'd101, 12'd101});
    check("t1_drain", exp_q.size(), 0);

    // Channel 2 silent: timed out after 50 request cycles, result held.
    base = 300; silent_ch = 2; ch2_req_cycles = 0;
    push_scan(4'hF);
    pulse_start(); wait_scans(2); idle(5);
    check("t2_err", ch_err, 4'b0100);
    check("t2_req_cycles", ch2_req_cycles, 50);
    check("t2_data", data_out, {12'd301, 12'd101, 12'd301, 12'd301});
    check("t2_drain", exp_q.size(), 0);
    silent_ch = -1; base = 400;
    push_scan(4'hF);
    pulse_start(); wait_scans(3); idle(5);
    check("t2_err_clr", ch_err, 0);
    check("t2_data2", data_out, {12'd401, 12'd401, 12'd401, 12'd401});

    // Reset after two real samples on channel 0.
    base = 500;
    pulse_start();
    c = 0;
    while (idx < 3 && c < 200) begin @(posedge clk); #1; c++; end
    check("t3_reach", idx >= 3, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t3_req", conv_req, 0);
    check("t3_busy", busy, 0);
    check("t3_data", data_out, 0);
    check("t3_err", ch_err, 0);
    check("t3_ch", conv_ch, 0);
    @(negedge clk); rst = 1'b0;
    base = 520; s0 = scan_cnt;
    push_scan(4'hF);
    pulse_start(); wait_scans(s0 + 1); idle(5);
    check("t3_fresh", data_out, {12'd521, 12'd521, 12'd521, 12'd521});
    check("t3_drain", exp_q.size(), 0);

    // Sparse mask from a clean reset.
    do_reset();
    base = 200; step = 16; ch_mask = 4'b1010; s0 = scan_cnt;
    req_log.delete(); push_scan(4'b1010);
    pulse_start(); wait_scans(s0 + 1); idle(5);
    check("t4_req_n", req_log.size(), 2);
    check("t4_req0", req_log[0], 1);
    check("t4_req1", req_log[1], 3);
    check("t4_d0", slice(data_out, 0), 0);
    check("t4_d1", slice(data_out, 1), 217);
    check("t4_d2", slice(data_out, 2), 0);
    check("t4_d3", slice(data_out, 3), 249);

    // Empty mask: start does nothing.
    ch_mask = '0; req_log.delete(); s0 = scan_cnt;
    @(negedge clk); busy_seen = 1'b0;
    pulse_start(); idle(20);
    check("t5_req_n", req_log.size(), 0);
    check("t5_scans", scan_cnt, s0);
    check("t5_busy", busy_seen, 0);

    // Continuous mode, en dropped during channel 2 of the third scan.
    ch_mask = 4'hF; base = 600; step = 16; s0 = scan_cnt;
    req_log.delete();
    push_scan(4'hF); push_scan(4'hF); push_scan(4'hF);
    @(negedge clk); en = 1'b1;
    c = 0;
    while (!(scan_cnt >= s0 + 2 && conv_req && conv_ch == 2'd2) && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    check("t6_third_ch2", scan_cnt >= s0 + 2 && conv_req && conv_ch == 2'd2, 1);
    en = 1'b0;
    wait_scans(s0 + 3); idle(60);
    check("t6_scans", scan_cnt, s0 + 3);
    check("t6_req_n", req_log.size(), 12);
    check("t6_last_ch", req_log[11], 3);
    check("t6_busy", busy, 0);
    check("t6_data", data_out, {12'd649, 12'd633, 12'd617, 12'd601});
    check("t6_drain", exp_q.size(), 0);

    // Limits: no averaging, no discard, full-scale samples.
    check("t7_rst_data", data_out_l, 0);
    @(negedge clk); start_l = 1'b1;
    @(negedge clk); start_l = 1'b0;
    c = 0; dv_l = 0;
    while (!scan_done_l && c < 200) begin
      @(posedge clk); #1; c++;
      dv_l += $countones(data_valid_l);
    end
    check("t7_done", scan_done_l, 1);
    check("t7_valid_n", dv_l, 4);
    check("t7_data", data_out_l, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF});
    check("t7_err", ch_err_l, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
